// File: rtl/gpio_apb_arb.sv
// gpio_apb_arb: round-robin arbiter sharing one two-phase APB slave port between two requesters
module gpio_apb_arb #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                  pclk,
    input  logic                  p_reset,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    output logic [1:0]            ack_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [31:0]           pwdata,
    input  logic [31:0]           prdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t              state_q, state_d;
    logic                owner_q, owner_d, last_gnt_q, last_gnt_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [1:0]          rvalid_q, rvalid_d, cand;
    logic                win, grant, rd_cap;
    logic                unused_prdata;
    assign unused_prdata = ^prdata[31:DATA_W];
    always_comb begin
        // the current owner is masked at the ACCESS arbitration point
        cand       = (state_q == ACCESS) ? (req_i & ~(2'b01 << owner_q)) : req_i;
        win        = (&cand) ? ~last_gnt_q : cand[1];
        grant      = (|cand) && (state_q != SETUP);
        state_d    = (state_q == SETUP) ? ACCESS : (grant ? SETUP : IDLE);
        owner_d    = grant ? win : owner_q;
        last_gnt_d = grant ? win : last_gnt_q;
        pwrite_d   = grant ? we_i[win] : pwrite_q;
        paddr_d    = grant ? (win ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0]) : paddr_q;
        pwdata_d   = grant ? (win ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0]) : pwdata_q;
        rd_cap     = (state_q == ACCESS) && !pwrite_q;
        rdata_d    = rd_cap ? prdata[DATA_W-1:0] : rdata_q;
        rvalid_d   = rd_cap ? (2'b01 << owner_q) : 2'b00;
    end
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end
    assign psel     = state_q != IDLE;
    assign penable  = state_q == ACCESS;
    assign ack_o    = (state_q == ACCESS) ? (2'b01 << owner_q) : 2'b00;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = {{(32-DATA_W){1'b0}}, pwdata_q};
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
endmodule

// File: doc/gpio_apb_arb.md
# gpio_apb_arb

Two-port APB master and arbiter that shares the single APB slave port of the 16-pin GPIO peripheral between two on-chip requesters, e.g. the CPU bridge and the power-management sequencer. It accepts simple request/acknowledge transactions, arbitrates round-robin, and drives a strictly two-phase APB transfer (SETUP then ACCESS) into the GPIO. Read data is captured and returned to the owning requester.

## Interface
- ADDR_W, 6, APB register address width
- DATA_W, 16, data width; the GPIO prdata upper bits are ignored
- pclk  in  1  APB clock; all logic on its rising edge
- p_reset  in  1  synchronous, active-high reset
- req_i[r], r=0..1  in  1  transfer request; held high with fields stable until ack
- we_i[r]  in  1  1 = write, 0 = read
- addr_i[r]  in  ADDR_W  register address
- wdata_i[r]  in  DATA_W  write data
- ack_o[r]  out  1  one-cycle pulse, high during the ACCESS cycle of r's transfer
- rvalid_o[r]  out  1  one-cycle pulse the cycle after a read's ACCESS; rdata_o valid
- rdata_o  out  DATA_W  captured read data, shared by both ports, held until the next capture
- psel, penable, pwrite  out  1  APB controls to GPIO
- paddr  out  ADDR_W; pwdata  out  32  APB address and data; pwdata[31:DATA_W] = 0
- prdata  in  32  APB read data from GPIO; only [DATA_W-1:0] used

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- IDLE: if any req_i is high, grant the winner, go to SETUP; else stay.
- SETUP: psel=1, penable=0; go to ACCESS unconditionally.
- ACCESS: psel=1, penable=1, ack_o[owner]=1. Arbitrate among requesters with owner masked. On a winner go to SETUP (back-to-back); else go to IDLE.
- Arbitration is round-robin. last_gnt flips to the granted index. If both requesters are high, the one ≠ last_gnt wins. Reset value of last_gnt = 1, so port 0 wins the first contention.
- At grant, pwrite, paddr and pwdata are loaded from the winner. They are held constant through SETUP and ACCESS and also in IDLE (no toggling).
- The GPIO read strobe occurs in SETUP with pwrite=0. prdata is valid in ACCESS and is captured into rdata_o at the end of ACCESS for reads only. rvalid_o[owner] pulses the next cycle.
- Writes never update rdata_o and never pulse rvalid_o.
- A requester must drop req_i on the clock edge that ends its ack cycle, or present a new transaction. A req_i still high in the cycle after ack is a new request.
- The arbiter has no error or wait handling; the GPIO has no pready/pslverr.

## Timing
- All outputs are registered except nothing; ack_o is decoded from the state register and owner register (no input-to-output paths).
- Reset (p_reset sampled high at an edge) forces the following from the next cycle:
  - state=IDLE, psel=0, penable=0, pwrite=0
  - paddr=0, pwdata=0, ack_o=0, rvalid_o=0, rdata_o=0, last_gnt=1
- Reset mid-transfer aborts the transfer without an ack. The requester must reissue.
- Latency: req_i high in an IDLE cycle T gives SETUP at T+1, ACCESS/ack at T+2, and rvalid at T+3.
- Throughput: back-to-back transfers take 2 cycles each. psel stays high across them; penable alternates 0/1.
- Alternation under contention: both requesters held high give strict alternation 0,1,0,1…
- Single requester streaming: repeated requests from the same port pass through IDLE, so each takes 3 cycles, because the owner is masked in ACCESS.
- Simultaneous events: a request arriving during SETUP is considered at the ACCESS arbitration point. A request during ACCESS by a non-owner is granted back-to-back.

## Test plan
- Reset: assert p_reset for 2 cycles mid-ACCESS -> psel=penable=ack_o=0 next cycle, rdata_o=0, no rvalid; the next contention is won by port 0.
- Single write: port 0 writes addr 0x04, data 0xA5A5 -> SETUP psel=1/penable=0, then ACCESS penable=1 with pwrite=1, paddr=0x04, pwdata=0x0000A5A5 and ack_o[0]=1; no rvalid.
- Single read: port 1 reads addr 0x08 and the GPIO returns prdata=0xFFFF1234 -> ack_o[1] in ACCESS; next cycle rvalid_o[1]=1 and rdata_o=0x1234.
- Contention: both ports request from IDLE after reset -> grants 0,1,0,1 over 4 transfers. psel is continuously high for 8 cycles and penable toggles each cycle.
- Owner masking: port 0 keeps req_i high for 3 consecutive reads -> each is separated by one IDLE cycle (3-cycle period). An ack never occurs without a preceding SETUP.
- Late arrival: port 1 raises req during port 0's SETUP -> port 1 enters SETUP immediately after port 0's ACCESS with no IDLE gap, and paddr/pwrite switch at that SETUP.
